// File: rtl/mem_copy_master_if.sv
// rtl/mem_copy_master_if.sv - single-port behavioural memory bus (wen/a/d/q)
interface mem_copy_master_if #(
    parameter int BITS = 32
);
    logic            wen;
    logic [BITS-1:0] a;
    logic [BITS-1:0] d;
    logic [BITS-1:0] q;

    modport master (
        output wen,
        output a,
        output d,
        input  q
    );

    modport slave (
        input  wen,
        input  a,
        input  d,
        output q
    );
endinterface

// File: rtl/mem_copy_master.sv
// rtl/mem_copy_master.sv - word-by-word memory block copier with running checksum
module mem_copy_master #(
    parameter int BITS  = 32,
    parameter int LEN_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BITS-1:0]       src_addr,
    input  logic [BITS-1:0]       dst_addr,
    input  logic [LEN_W-1:0]      len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [BITS-1:0]       checksum,
    mem_copy_master_if.master     mem
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [BITS-1:0]   src_q, src_d;
    logic [BITS-1:0]   dst_q, dst_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [BITS-1:0]   data_q, data_d;
    logic [BITS-1:0]   checksum_q, checksum_d;
    logic              wen_q, wen_d;
    logic [BITS-1:0]   a_q, a_d;
    logic [BITS-1:0]   d_q, d_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // Next-state and next-output decode; outputs are computed for the state being
    // entered so that every output leaves a flop aligned with state_q.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        count_d    = count_q;
        data_d     = data_q;
        checksum_d = checksum_q;
        a_d        = a_q;
        d_d        = d_q;
        wen_d      = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00)) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else if (len == '0) begin
                        state_d    = S_DONE;
                        checksum_d = '0;
                        done_d     = 1'b1;
                    end else begin
                        state_d    = S_READ;
                        src_d      = src_addr;
                        dst_d      = dst_addr;
                        count_d    = len;
                        checksum_d = '0;
                        a_d        = src_addr;
                        busy_d     = 1'b1;
                    end
                end
            end
            S_READ: begin
                // q is combinational off a, so the read completes at this edge.
                data_d     = mem.q;
                checksum_d = checksum_q + mem.q;
                state_d    = S_WRITE;
                a_d        = dst_q;
                d_d        = mem.q;
                wen_d      = 1'b1;
                busy_d     = 1'b1;
            end
            S_WRITE: begin
                count_d = count_q - LEN_W'(1);
                src_d   = src_q + BITS'(4);
                dst_d   = dst_q + BITS'(4);
                if (count_q == LEN_W'(1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_READ;
                    a_d     = src_q + BITS'(4);
                    busy_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset (rst_n high) wins over everything.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            count_q    <= '0;
            data_q     <= '0;
            checksum_q <= '0;
            wen_q      <= 1'b0;
            a_q        <= '0;
            d_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            count_q    <= count_d;
            data_q     <= data_d;
            checksum_q <= checksum_d;
            wen_q      <= wen_d;
            a_q        <= a_d;
            d_q        <= d_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign mem.wen  = wen_q;
    assign mem.a    = a_q;
    assign mem.d    = d_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign checksum = checksum_q;

    logic unused_data;
    assign unused_data = ^data_q;
endmodule

// File: tb/tb_mem_copy_master.sv
// tb/tb_mem_copy_master.sv - directed self-checking bench for mem_copy_master
module tb_mem_copy_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] len = '0;
    logic        busy, done, err;
    logic [31:0] checksum;

    mem_copy_master_if #(.BITS(32)) mif ();

    mem_copy_master #(.BITS(32), .LEN_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .checksum (checksum),
        .mem      (mif)
    );

    always #5 clk = ~clk;

    // Behavioural memory: offset 0x1000, 32 words, Z outside its range.
    logic [31:0] mem [0:31];
    logic        pl_en = 1'b0;
    logic [4:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;

    function automatic bit in_range(input logic [31:0] addr);
        return (addr >= 32'h1000) && (addr < 32'h1080);
    endfunction

    assign mif.q = in_range(mif.a) ? mem[mif.a[6:2]] : 32'hzzzz_zzzz;

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_idx] <= pl_data;
        else if (mif.wen && in_range(mif.a))
            mem[mif.a[6:2]] <= mif.d;
    end

    int checks = 0;
    int failures = 0;

    logic        busy_h [1:40];
    logic        wen_h  [1:40];
    logic        done_h [1:40];
    logic        err_h  [1:40];
    logic [31:0] a_h    [1:40];

    task automatic poke(input int idx, input logic [31:0] val);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_idx  = idx[4:0];
        pl_data = val;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic launch(input logic [31:0] s, input logic [31:0] dd, input logic [15:0] l,
                          input int ncyc, input int hold);
        @(negedge clk);
        src_addr = s;
        dst_addr = dd;
        len      = l;
        start    = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            busy_h[k] = busy;
            wen_h[k]  = mif.wen;
            done_h[k] = done;
            err_h[k]  = err;
            a_h[k]    = mif.a;
            if (k >= hold) start = 1'b0;
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 32; i++) poke(i, 32'h0);
        @(negedge clk);
        checks++;
        if ({busy, done, err, mif.wen} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=0000", {busy, done, err, mif.wen});
        end
        checks++;
        if ({mif.a, mif.d, checksum} !== 96'h0) begin
            failures++;
            $display("FAIL reset_regs a=%h d=%h checksum=%h want zeros", mif.a, mif.d, checksum);
        end
        rst_n = 1'b0;
    endtask

    task automatic test_copy4;
        logic [31:0] pre [0:3];
        pre[0] = 32'h11; pre[1] = 32'h22; pre[2] = 32'h33; pre[3] = 32'h44;
        for (int i = 0; i < 4; i++) poke(i, pre[i]);
        launch(32'h1000, 32'h1040, 16'd4, 12, 1);
        for (int k = 1; k <= 12; k++) begin
            logic [2:0] exp;
            exp = {k <= 8, (k <= 8) && (k % 2 == 0), k == 9};
            checks++;
            if ({busy_h[k], wen_h[k], done_h[k]} !== exp) begin
                failures++;
                $display("FAIL copy4_cycle%0d busy/wen/done got=%b want=%b", k,
                         {busy_h[k], wen_h[k], done_h[k]}, exp);
            end
        end
        checks++;
        if (checksum !== 32'hAA) begin
            failures++;
            $display("FAIL copy4_checksum got=%h want=000000aa", checksum);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[16 + i] !== pre[i]) begin
                failures++;
                $display("FAIL copy4_dst%0d got=%h want=%h", i, mem[16 + i], pre[i]);
            end
        end
    endtask

    task automatic test_misaligned;
        logic [31:0] snap [0:31];
        for (int i = 0; i < 32; i++) snap[i] = mem[i];
        launch(32'h1002, 32'h1050, 16'd3, 6, 1);
        checks++;
        if (err_h[1] !== 1'b1) begin
            failures++;
            $display("FAIL misaligned_err_pulse got=%b want=1", err_h[1]);
        end
        for (int k = 1; k <= 6; k++) begin
            checks++;
            if ({busy_h[k], wen_h[k], done_h[k], (k > 1) && err_h[k]} !== 4'b0000) begin
                failures++;
                $display("FAIL misaligned_cycle%0d busy/wen/done/err got=%b%b%b%b want=0000 (err only in cycle 1)",
                         k, busy_h[k], wen_h[k], done_h[k], err_h[k]);
            end
        end
        checks++;
        if (checksum !== 32'hAA) begin
            failures++;
            $display("FAIL misaligned_checksum got=%h want=000000aa", checksum);
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (mem[i] !== snap[i]) begin
                failures++;
                $display("FAIL misaligned_mem%0d got=%h want=%h", i, mem[i], snap[i]);
            end
        end
    endtask

    task automatic test_len_zero;
        launch(32'h1000, 32'h1040, 16'd0, 4, 1);
        checks++;
        if (done_h[1] !== 1'b1 || done_h[2] !== 1'b0) begin
            failures++;
            $display("FAIL len0_done got=%b%b want=10", done_h[1], done_h[2]);
        end
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if ({busy_h[k], wen_h[k]} !== 2'b00) begin
                failures++;
                $display("FAIL len0_cycle%0d busy/wen got=%b want=00", k, {busy_h[k], wen_h[k]});
            end
        end
        checks++;
        if (checksum !== 32'h0) begin
            failures++;
            $display("FAIL len0_checksum got=%h want=00000000", checksum);
        end
    endtask

    task automatic test_reset_mid_copy;
        int done_seen;
        for (int i = 0; i < 8; i++) poke(i, 32'h100 + i);
        for (int i = 8; i < 16; i++) poke(i, 32'h0);
        launch(32'h1000, 32'h1020, 16'd8, 6, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({mif.wen, busy, done} !== 3'b000) begin
            failures++;
            $display("FAIL midreset_after_edge wen/busy/done got=%b want=000", {mif.wen, busy, done});
        end
        rst_n = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || busy || mif.wen) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            failures++;
            $display("FAIL midreset_quiet activity_cycles got=%0d want=0", done_seen);
        end
        for (int i = 8; i < 16; i++) begin
            logic [31:0] exp;
            exp = (i < 11) ? 32'h100 + (i - 8) : 32'h0;
            checks++;
            if (mem[i] !== exp) begin
                failures++;
                $display("FAIL midreset_dst%0d got=%h want=%h", i - 8, mem[i], exp);
            end
        end
    endtask

    task automatic test_wrap_and_retrigger;
        logic [31:0] exp_a [1:4];
        exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h1060; exp_a[3] = 32'h0; exp_a[4] = 32'h1064;
        launch(32'hFFFF_FFFC, 32'h1060, 16'd2, 8, 6);
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (a_h[k] !== exp_a[k] || busy_h[k] !== 1'b1) begin
                failures++;
                $display("FAIL wrap_cycle%0d a got=%h want=%h busy got=%b want=1", k, a_h[k], exp_a[k], busy_h[k]);
            end
        end
        for (int k = 5; k <= 8; k++) begin
            checks++;
            if ({busy_h[k], done_h[k]} !== {1'b0, k == 5}) begin
                failures++;
                $display("FAIL wrap_tail_cycle%0d busy/done got=%b want=%b", k,
                         {busy_h[k], done_h[k]}, {1'b0, k == 5});
            end
        end
    endtask

    task automatic test_checksum_wrap;
        poke(0, 32'hFFFF_FFFF);
        poke(1, 32'h0000_0002);
        launch(32'h1000, 32'h1070, 16'd2, 6, 1);
        checks++;
        if (done_h[5] !== 1'b1) begin
            failures++;
            $display("FAIL cksum_done got=%b want=1", done_h[5]);
        end
        checks++;
        if (checksum !== 32'h0000_0001) begin
            failures++;
            $display("FAIL cksum_value got=%h want=00000001", checksum);
        end
        checks++;
        if (mem[28] !== 32'hFFFF_FFFF || mem[29] !== 32'h2) begin
            failures++;
            $display("FAIL cksum_dst got=%h,%h want=ffffffff,00000002", mem[28], mem[29]);
        end
    endtask

    initial begin
        test_reset;
        test_copy4;
        test_misaligned;
        test_len_zero;
        test_reset_mid_copy;
        test_wrap_and_retrigger;
        test_checksum_wrap;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
